// File: rtl/dma_priority_resolver.sv
// DMA channel priority resolver: HRQ/HLDA handshake, fixed or rotating arbitration, grant held until serviceDone (no backpressure path).
// Latency: HRQ 1 cycle after a request, DACK 1 cycle after HLDA; defining DMA_DREQ_SYNC_EN adds a 2-flop DREQ synchronizer (+2 cycles).
module dma_priority_resolver #(
    parameter int NUM_CH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic [7:0]        commandReg,
    input  logic [7:0]        requestReg,
    input  logic [7:0]        maskReg,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [1:0]        grantChannel,
    output logic [NUM_CH-1:0] pendingReq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GNT  = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        hi_ptr_q, hi_ptr_d;
    logic [1:0]        grant_ch_q, grant_ch_d;
    logic [NUM_CH-1:0] dreq_raw;
    logic [NUM_CH-1:0] dreq_act;
    logic [NUM_CH-1:0] eff_req;
    logic              any_req;
    logic              arb_found;
    logic [1:0]        arb_ch;
    logic              unused_bits;

    assign unused_bits = &{1'b0, commandReg[5], commandReg[3], commandReg[1:0],
                           requestReg[7:4], maskReg[7:4]};

`ifdef DMA_DREQ_SYNC_EN
    logic [NUM_CH-1:0] sync_meta_q, sync_meta_d;
    logic [NUM_CH-1:0] dreq_sync_q, dreq_sync_d;

    always_comb begin
        sync_meta_d = DREQ;
        dreq_sync_d = sync_meta_q;
    end

    // Reset to the pin's inactive level so no phantom request appears after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_meta_q <= {NUM_CH{commandReg[6]}};
            dreq_sync_q <= {NUM_CH{commandReg[6]}};
        end else begin
            sync_meta_q <= sync_meta_d;
            dreq_sync_q <= dreq_sync_d;
        end
    end

    assign dreq_raw = dreq_sync_q;
`else
    assign dreq_raw = DREQ;
`endif

    assign dreq_act   = dreq_raw ^ {NUM_CH{commandReg[6]}};
    assign eff_req    = (dreq_act & ~maskReg[NUM_CH-1:0]) | requestReg[NUM_CH-1:0];
    assign any_req    = |eff_req;
    assign pendingReq = eff_req;

    // Scan from hi_ptr upward with wrap; first requesting channel wins.
    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        arb_found = 1'b0;
        arb_ch    = hi_ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = hi_ptr_q + 2'(k);
            if (!arb_found && eff_req[idx]) begin
                arb_found = 1'b1;
                arb_ch    = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_ch_d = grant_ch_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req && !commandReg[2]) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (HLDA && any_req) begin
                    state_d    = ST_GNT;
                    grant_ch_d = arb_ch;
                end else if (HLDA) begin
                    state_d = ST_REL;
                end else if (!any_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT: begin
                if (serviceDone) begin
                    state_d = ST_REL;
                end else if (!HLDA) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REL: begin
                if (!HLDA) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_ptr_d = hi_ptr_q;
        if (!commandReg[4]) begin
            hi_ptr_d = 2'd0;
        end else if (state_q == ST_GNT && serviceDone) begin
            hi_ptr_d = grant_ch_q + 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            hi_ptr_q   <= 2'd0;
            grant_ch_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            hi_ptr_q   <= hi_ptr_d;
            grant_ch_q <= grant_ch_d;
        end
    end

    assign HRQ          = (state_q == ST_REQ) || (state_q == ST_GNT);
    assign grantValid   = (state_q == ST_GNT);
    assign grantChannel = grant_ch_q;

    // Pin polarity is applied after the state decode so a commandReg[7] flip is immediate.
    always_comb begin
        DACK = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            DACK[i] = (grantValid && grant_ch_q == 2'(i)) ? commandReg[7] : ~commandReg[7];
        end
    end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver (default build, DREQ unsynchronized).
module tb_dma_priority_resolver;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ;
    logic       HLDA;
    logic [7:0] commandReg;
    logic [7:0] requestReg;
    logic [7:0] maskReg;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic [3:0] pendingReq;

    int tests_run = 0;
    int tests_failed = 0;

    dma_priority_resolver #(.NUM_CH(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DREQ        (DREQ),
        .HLDA        (HLDA),
        .commandReg  (commandReg),
        .requestReg  (requestReg),
        .maskReg     (maskReg),
        .serviceDone (serviceDone),
        .HRQ         (HRQ),
        .DACK        (DACK),
        .grantValid  (grantValid),
        .grantChannel(grantChannel),
        .pendingReq  (pendingReq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; commandReg = 8'h00; requestReg = 8'h00; maskReg = 8'h0F;
        DREQ = 4'hF; HLDA = 1'b0; serviceDone = 1'b0;
        tick(); tick();
        tests_run++; if (HRQ !== 1'b0) begin tests_failed++; $display("FAIL reset_hrq got=%b exp=0", HRQ); end
        tests_run++; if (DACK !== 4'hF) begin tests_failed++; $display("FAIL reset_dack got=%b exp=1111", DACK); end
        tests_run++; if (grantValid !== 1'b0) begin tests_failed++; $display("FAIL reset_gv got=%b exp=0", grantValid); end
        tests_run++; if (pendingReq !== 4'h0) begin tests_failed++; $display("FAIL reset_pending got=%b exp=0000", pendingReq); end
        tests_run++; if (grantChannel !== 2'd0) begin tests_failed++; $display("FAIL reset_gch got=%0d exp=0", grantChannel); end
        RESET = 1'b0;
        tick();
        tests_run++; if (HRQ !== 1'b0) begin tests_failed++; $display("FAIL reset_masked_idle got=%b exp=0", HRQ); end
    endtask

    task automatic test_fixed();
        maskReg = 8'h00; commandReg = 8'h00; DREQ = 4'b0101;
        #1;
        tests_run++; if (pendingReq !== 4'b0101) begin tests_failed++; $display("FAIL fixed_pending got=%b exp=0101", pendingReq); end
        tick();
        tests_run++; if (HRQ !== 1'b1) begin tests_failed++; $display("FAIL fixed_hrq got=%b exp=1", HRQ); end
        tests_run++; if (grantValid !== 1'b0) begin tests_failed++; $display("FAIL fixed_gv_req got=%b exp=0", grantValid); end
        HLDA = 1'b1;
        tick();
        tests_run++; if (grantChannel !== 2'd0) begin tests_failed++; $display("FAIL fixed_gch0 got=%0d exp=0", grantChannel); end
        tests_run++; if (DACK !== 4'b1110) begin tests_failed++; $display("FAIL fixed_dack0 got=%b exp=1110", DACK); end
        tests_run++; if (grantValid !== 1'b1) begin tests_failed++; $display("FAIL fixed_gv got=%b exp=1", grantValid); end
        DREQ = 4'b0100; serviceDone = 1'b1;
        tick();
        serviceDone = 1'b0;
        tests_run++; if (HRQ !== 1'b0 || DACK !== 4'hF || grantValid !== 1'b0) begin
            tests_failed++; $display("FAIL fixed_rel got hrq=%b dack=%b gv=%b exp 0/1111/0", HRQ, DACK, grantValid); end
        HLDA = 1'b0;
        tick();
        tests_run++; if (HRQ !== 1'b0) begin tests_failed++; $display("FAIL fixed_idle_gap got=%b exp=0", HRQ); end
        tick();
        tests_run++; if (HRQ !== 1'b1) begin tests_failed++; $display("FAIL fixed_hrq2 got=%b exp=1", HRQ); end
        HLDA = 1'b1;
        tick();
        tests_run++; if (grantChannel !== 2'd2 || DACK !== 4'b1011) begin
            tests_failed++; $display("FAIL fixed_gch2 got ch=%0d dack=%b exp 2/1011", grantChannel, DACK); end
        commandReg = 8'h80;
        #1;
        tests_run++; if (DACK !== 4'b0100) begin tests_failed++; $display("FAIL dack_polarity got=%b exp=0100", DACK); end
        commandReg = 8'h00; DREQ = 4'b0000; serviceDone = 1'b1;
        tick();
        serviceDone = 1'b0; HLDA = 1'b0;
        tick();
    endtask

    task automatic test_rotating();
        logic [1:0] exp_ch [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        logic [1:0] exp_hi [4] = '{2'd2, 2'd0, 2'd2, 2'd0};
        commandReg = 8'h10; DREQ = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            HLDA = 1'b0;
            tick();
            HLDA = 1'b1;
            tick();
            tests_run++; if (grantChannel !== exp_ch[n]) begin
                tests_failed++; $display("FAIL rot_grant[%0d] got=%0d exp=%0d", n, grantChannel, exp_ch[n]); end
            serviceDone = 1'b1;
            tick();
            serviceDone = 1'b0;
            tests_run++; if (dut.hi_ptr_q !== exp_hi[n]) begin
                tests_failed++; $display("FAIL rot_hiptr[%0d] got=%0d exp=%0d", n, dut.hi_ptr_q, exp_hi[n]); end
            HLDA = 1'b0;
            tick();
        end
        DREQ = 4'b0010;
        tick();
        HLDA = 1'b1;
        tick();
        serviceDone = 1'b1;
        tick();
        serviceDone = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
        tests_run++; if (dut.hi_ptr_q !== 2'd2) begin tests_failed++; $display("FAIL rot_hiptr_pre got=%0d exp=2", dut.hi_ptr_q); end
        commandReg = 8'h00;
        tick();
        tests_run++; if (dut.hi_ptr_q !== 2'd0) begin tests_failed++; $display("FAIL rot_clear got=%0d exp=0", dut.hi_ptr_q); end
    endtask

    task automatic test_mask();
        maskReg = 8'h0F; DREQ = 4'hF; commandReg = 8'h00;
        #1;
        tests_run++; if (pendingReq !== 4'h0) begin tests_failed++; $display("FAIL mask_pending got=%b exp=0000", pendingReq); end
        tick(); tick();
        tests_run++; if (HRQ !== 1'b0) begin tests_failed++; $display("FAIL mask_hrq got=%b exp=0", HRQ); end
        requestReg = 8'h04;
        #1;
        tests_run++; if (pendingReq !== 4'b0100) begin tests_failed++; $display("FAIL swreq_pending got=%b exp=0100", pendingReq); end
        tick();
        tests_run++; if (HRQ !== 1'b1) begin tests_failed++; $display("FAIL swreq_hrq got=%b exp=1", HRQ); end
        HLDA = 1'b1;
        tick();
        tests_run++; if (grantChannel !== 2'd2 || DACK !== 4'b1011) begin
            tests_failed++; $display("FAIL swreq_grant got ch=%0d dack=%b exp 2/1011", grantChannel, DACK); end
        serviceDone = 1'b1;
        tick();
        serviceDone = 1'b0; requestReg = 8'h00; HLDA = 1'b0; DREQ = 4'h0; maskReg = 8'h00;
        tick();
    endtask

    task automatic test_abort();
        commandReg = 8'h10; serviceDone = 1'b1;
        tick();
        serviceDone = 1'b0;
        tests_run++; if (dut.hi_ptr_q !== 2'd0) begin tests_failed++; $display("FAIL done_outside_gnt got=%0d exp=0", dut.hi_ptr_q); end
        DREQ = 4'b0010;
        tick();
        HLDA = 1'b1;
        tick();
        tests_run++; if (grantChannel !== 2'd1) begin tests_failed++; $display("FAIL abort_grant got=%0d exp=1", grantChannel); end
        HLDA = 1'b0;
        tick();
        tests_run++; if (DACK !== 4'hF || grantValid !== 1'b0 || HRQ !== 1'b0) begin
            tests_failed++; $display("FAIL abort_drop got dack=%b gv=%b hrq=%b exp 1111/0/0", DACK, grantValid, HRQ); end
        tests_run++; if (dut.hi_ptr_q !== 2'd0) begin tests_failed++; $display("FAIL abort_hiptr got=%0d exp=0", dut.hi_ptr_q); end
        tick();
        HLDA = 1'b1;
        tick();
        HLDA = 1'b0; serviceDone = 1'b1;
        tick();
        serviceDone = 1'b0;
        tests_run++; if (dut.hi_ptr_q !== 2'd2 || HRQ !== 1'b0) begin
            tests_failed++; $display("FAIL done_with_hlda_fall got hi=%0d hrq=%b exp 2/0", dut.hi_ptr_q, HRQ); end
        DREQ = 4'b0000; commandReg = 8'h00;
        tick(); tick();
    endtask

    task automatic test_disable();
        DREQ = 4'b0001;
        tick();
        HLDA = 1'b1;
        tick();
        commandReg = 8'h04; maskReg = 8'h0F;
        tick();
        tests_run++; if (grantValid !== 1'b1 || grantChannel !== 2'd0 || DACK !== 4'b1110) begin
            tests_failed++; $display("FAIL disable_no_preempt got gv=%b ch=%0d dack=%b exp 1/0/1110", grantValid, grantChannel, DACK); end
        maskReg = 8'h00; serviceDone = 1'b1;
        tick();
        serviceDone = 1'b0; HLDA = 1'b0;
        tick(); tick(); tick();
        tests_run++; if (HRQ !== 1'b0) begin tests_failed++; $display("FAIL disable_blocks got=%b exp=0", HRQ); end
        commandReg = 8'h00;
        tick();
        tests_run++; if (HRQ !== 1'b1) begin tests_failed++; $display("FAIL enable_hrq got=%b exp=1", HRQ); end
    endtask

    task automatic test_reset_mid_grant();
        HLDA = 1'b1;
        tick();
        tests_run++; if (grantValid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_gv got=%b exp=1", grantValid); end
        RESET = 1'b1;
        tick();
        tests_run++; if (HRQ !== 1'b0 || DACK !== 4'hF || grantValid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid got hrq=%b dack=%b gv=%b exp 0/1111/0", HRQ, DACK, grantValid); end
        RESET = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rotating();
        test_mask();
        test_abort();
        test_disable();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
